// File: rtl/mdu_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer with HI/LO register file for the EX stage.
// Optional build macro MDU_DIV0_FAST_EN: divide by zero finishes after one busy cycle.
module mdu_sequencer #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  MDUOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        start,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDUOut
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    localparam logic [3:0] MUL_LAT = 4'(MUL_CYCLES - 1);
    localparam logic [3:0] DIV_LAT = 4'(DIV_CYCLES - 1);

    typedef enum logic [0:0] {IDLE, BUSY} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [3:0]  op_q;
    logic        bzero_q;
    logic [63:0] pend;

    logic        is_div;
    logic        is_sgn;
    logic        b_zero;
    logic        skip_commit;
    logic [3:0]  launch_cnt;

    function automatic logic [63:0] mul_res(input logic sgn, input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        sa = sgn ? {{32{a[31]}}, a} : {32'd0, a};
        sb = sgn ? {{32{b[31]}}, b} : {32'd0, b};
        mul_res = sa * sb;
    endfunction

    // Result packed as {remainder, quotient}; the -2^31 / -1 case is resolved explicitly.
    function automatic logic [63:0] div_res(input logic sgn, input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        if (b == 32'd0)
            div_res = 64'd0;
        else if (sgn && b == 32'hFFFF_FFFF)
            div_res = {32'd0, 32'd0 - a};
        else if (sgn)
            div_res = {sa % sb, sa / sb};
        else
            div_res = {a % b, a / b};
    endfunction

    assign start  = (MDUOp >= OP_MULT) && (MDUOp <= OP_DIVU) && (state == IDLE);
    assign is_div = (MDUOp == OP_DIV) || (MDUOp == OP_DIVU);
    assign is_sgn = (MDUOp == OP_MULT) || (MDUOp == OP_DIV);
    assign b_zero = (B == 32'd0);

`ifdef MDU_DIV0_FAST_EN
    assign launch_cnt = is_div ? (b_zero ? 4'd0 : DIV_LAT) : MUL_LAT;
`else
    assign launch_cnt = is_div ? DIV_LAT : MUL_LAT;
`endif

    assign skip_commit = ((op_q == OP_DIV) || (op_q == OP_DIVU)) && bzero_q;

    assign MDUOut = (MDUOp == OP_MFHI) ? HI :
                    (MDUOp == OP_MFLO) ? LO : 32'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            cnt     <= 4'd0;
            op_q    <= 4'd0;
            bzero_q <= 1'b0;
            pend    <= 64'd0;
            HI      <= 32'd0;
            LO      <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= 4'd0;
                    if (start) begin
                        op_q    <= MDUOp;
                        bzero_q <= b_zero;
                        pend    <= is_div ? div_res(is_sgn, A, B) : mul_res(is_sgn, A, B);
                        cnt     <= launch_cnt;
                        busy    <= 1'b1;
                        state   <= BUSY;
                    end else if (MDUOp == OP_MTHI) begin
                        HI <= A;
                    end else if (MDUOp == OP_MTLO) begin
                        LO <= A;
                    end
                end
                BUSY: begin
                    // Last busy cycle: results land at this edge unless the divisor was zero.
                    if (cnt == 4'd0) begin
                        if (!skip_commit) begin
                            HI <= pend[63:32];
                            LO <= pend[31:0];
                        end
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    cnt   <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Bench for mdu_sequencer: directed cases with literal results, then random traffic
// checked every cycle against a cycle-count/arithmetic model of HI, LO and busy.
module tb_mdu_sequencer;

    logic        clk;
    logic        reset;
    logic [3:0]  MDUOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        start;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDUOut;

    int tests = 0;
    int fails = 0;

    // Model state: committed HI/LO, remaining busy cycles, pending result.
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic [63:0] m_pend = 64'd0;
    int          m_rem = 0;
    bit          m_commit = 1'b0;
    bit          m_valid = 1'b0;

    mdu_sequencer dut (
        .clk(clk), .reset(reset), .MDUOp(MDUOp), .A(A), .B(B),
        .start(start), .busy(busy), .HI(HI), .LO(LO), .MDUOut(MDUOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_check();
        logic        e_start;
        logic [31:0] e_out;
        e_start = (MDUOp >= 4'd1) && (MDUOp <= 4'd4) && (m_rem == 0);
        e_out   = (MDUOp == 4'd5) ? m_hi : (MDUOp == 4'd6) ? m_lo : 32'd0;
        chk("busy", {31'd0, busy}, {31'd0, m_rem > 0});
        chk("start", {31'd0, start}, {31'd0, e_start});
        chk("HI", HI, m_hi);
        chk("LO", LO, m_lo);
        chk("MDUOut", MDUOut, e_out);
    endtask

    // Advance the model across the coming clock edge using the current inputs.
    task automatic model_step();
        longint          sa, sb;
        longint unsigned ua, ub;
        sa = $signed(A);
        sb = $signed(B);
        ua = {32'd0, A};
        ub = {32'd0, B};
        if (reset) begin
            m_rem = 0; m_hi = 32'd0; m_lo = 32'd0; m_valid = 1'b1;
        end else if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0 && m_commit) begin
                m_hi = m_pend[63:32];
                m_lo = m_pend[31:0];
            end
        end else if (MDUOp >= 4'd1 && MDUOp <= 4'd4) begin
            m_commit = 1'b1;
            case (MDUOp)
                4'd1: begin m_pend = sa * sb; m_rem = 5; end
                4'd2: begin m_pend = ua * ub; m_rem = 5; end
                default: begin
                    m_rem = 10;
                    if (B == 32'd0) begin
                        m_commit = 1'b0;
`ifdef MDU_DIV0_FAST_EN
                        m_rem = 1;
`endif
                    end else if (MDUOp == 4'd3) begin
                        m_pend = {32'(sa % sb), 32'(sa / sb)};
                    end else begin
                        m_pend = {32'(ua % ub), 32'(ua / ub)};
                    end
                end
            endcase
        end else if (MDUOp == 4'd7) begin
            m_hi = A;
        end else if (MDUOp == 4'd8) begin
            m_lo = A;
        end
    endtask

    // One clock cycle: apply inputs, compare mid-cycle, step the model, cross the edge.
    task automatic cyc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic r);
        MDUOp = op; A = a; B = b; reset = r;
        @(negedge clk);
        if (m_valid) model_check();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int n);
        cyc(op, a, b, 1'b0);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            cyc(4'd0, 32'd0, 32'd0, 1'b0);
        end
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 7))
            0: rnd_val = 32'd0;
            1: rnd_val = 32'hFFFF_FFFF;
            2: rnd_val = 32'h8000_0000;
            3: rnd_val = 32'd1;
            4: rnd_val = 32'(($urandom_range(0, 40)));
            default: rnd_val = $urandom;
        endcase
    endfunction

    initial begin
        int n;
        int exp_div0;
        MDUOp = 4'd0; A = 32'd0; B = 32'd0; reset = 1'b1;
        cyc(4'd0, 32'd0, 32'd0, 1'b1);
        cyc(4'd0, 32'd0, 32'd0, 1'b1);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_HI", HI, 32'd0);
        chk("reset_LO", LO, 32'd0);

        run_op(4'd1, 32'hFFFF_FFFE, 32'd3, n);
        chk("mult_cycles", n, 32'd5);
        chk("mult_HI", HI, 32'hFFFF_FFFF);
        chk("mult_LO", LO, 32'hFFFF_FFFA);
        run_op(4'd2, 32'hFFFF_FFFE, 32'd3, n);
        chk("multu_HI", HI, 32'h0000_0002);
        chk("multu_LO", LO, 32'hFFFF_FFFA);

        run_op(4'd3, 32'hFFFF_FFF9, 32'd2, n);
        chk("div_cycles", n, 32'd10);
        chk("div_LO", LO, 32'hFFFF_FFFD);
        chk("div_HI", HI, 32'hFFFF_FFFF);
        run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, n);
        chk("divovf_LO", LO, 32'h8000_0000);
        chk("divovf_HI", HI, 32'd0);
        run_op(4'd4, 32'd7, 32'd2, n);
        chk("divu_LO", LO, 32'd3);
        chk("divu_HI", HI, 32'd1);

        cyc(4'd7, 32'h1234_5678, 32'd0, 1'b0);
        chk("mthi_HI", HI, 32'h1234_5678);
        MDUOp = 4'd5; #1;
        chk("mfhi_out", MDUOut, 32'h1234_5678);
        MDUOp = 4'd6; #1;
        chk("mflo_out", MDUOut, 32'd3);
        MDUOp = 4'd0; #1;
        chk("none_out", MDUOut, 32'd0);

        cyc(4'd7, 32'hAA, 32'd0, 1'b0);
        cyc(4'd8, 32'hBB, 32'd0, 1'b0);
`ifdef MDU_DIV0_FAST_EN
        exp_div0 = 1;
`else
        exp_div0 = 10;
`endif
        run_op(4'd3, 32'd99, 32'd0, n);
        chk("div0_cycles", n, exp_div0);
        chk("div0_HI", HI, 32'hAA);
        chk("div0_LO", LO, 32'hBB);
        run_op(4'd4, 32'd99, 32'd0, n);
        chk("divu0_HI", HI, 32'hAA);
        chk("divu0_LO", LO, 32'hBB);

        cyc(4'd1, 32'd6, 32'd7, 1'b0);
        MDUOp = 4'd1; A = 32'd2; B = 32'd2; #1;
        chk("hold_start", {31'd0, start}, 32'd0);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            cyc(4'd1, 32'd2, 32'd2, 1'b0);
        end
        chk("hold_HI", HI, 32'd0);
        chk("hold_LO", LO, 32'd42);
        chk("restart", {31'd0, start}, 32'd1);
        run_op(4'd1, 32'd2, 32'd2, n);
        chk("second_LO", LO, 32'd4);

        cyc(4'd7, 32'h11, 32'd0, 1'b0);
        cyc(4'd8, 32'h22, 32'd0, 1'b0);
        cyc(4'd3, 32'd100, 32'd7, 1'b0);
        cyc(4'd0, 32'd0, 32'd0, 1'b0);
        cyc(4'd0, 32'd0, 32'd0, 1'b0);
        chk("rst_mid_busy", {31'd0, busy}, 32'd1);
        cyc(4'd0, 32'd0, 32'd0, 1'b1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_HI", HI, 32'd0);
        chk("rst_LO", LO, 32'd0);
        MDUOp = 4'd1; A = 32'd0; B = 32'd0; reset = 1'b0; #1;
        chk("rst_start", {31'd0, start}, 32'd1);
        cyc(4'd1, 32'd0, 32'd0, 1'b0);
        for (int i = 0; i < 15; i++) cyc(4'd0, 32'd0, 32'd0, 1'b0);
        chk("no_late_HI", HI, 32'd0);
        chk("no_late_LO", LO, 32'd0);

        for (int i = 0; i < 1500; i++) begin
            cyc(4'($urandom_range(0, 8)), rnd_val(), rnd_val(),
                ($urandom_range(0, 79) == 0));
        end
        for (int i = 0; i < 12; i++) cyc(4'd0, 32'd0, 32'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
